// File: rtl/grad_descent_ctrl_if.sv
// ---------------------------------------------------------------------------
// grad_descent_ctrl_if
// Request/result handshake between the gradient-descent controller
// (requester, master modport) and the function evaluator (slave modport).
//
// Signals:
//   start_func          requester -> evaluator  evaluation request (level)
//   a_out..d_out [15:0] requester -> evaluator  Q8.8 operands
//   func_done           evaluator -> requester  result valid (level)
//   z_in        [31:0]  evaluator -> requester  Q24.8 signed result
// ---------------------------------------------------------------------------
interface grad_descent_ctrl_if;
    logic        start_func;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [15:0] c_out;
    logic [15:0] d_out;
    logic        func_done;
    logic [31:0] z_in;

    modport master (
        output start_func, a_out, b_out, c_out, d_out,
        input  func_done, z_in
    );

    modport slave (
        input  start_func, a_out, b_out, c_out, d_out,
        output func_done, z_in
    );
endinterface

// File: rtl/grad_descent_ctrl.sv
// ---------------------------------------------------------------------------
// grad_descent_ctrl
// Iteration controller for the 4D gradient-descent datapath. Each iteration
// evaluates f at the base point and at four forward-perturbed points, forms
// the forward-difference gradient and updates a..d with shift-only math.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a run (sampled only while idle)
//   a_init..d_init [15:0] starting point, Q8.8 signed
//   iter_max              iterations to run
//   func_bus              master side of the evaluator handshake
//   a_final..d_final      final parameters, Q8.8
//   z_final [31:0]        f at the final parameters, Q24.8
//   iter_count            iterations completed
//   busy, done            run in progress / run complete (held)
//
// Optional feature macro: GD_EARLY_STOP_EN -- when defined, a run finishes
// early once an update leaves all four parameters unchanged (all deltas 0).
// ---------------------------------------------------------------------------
module grad_descent_ctrl #(
    parameter int STEP_SHIFT = 4,
    parameter int LR_SHIFT   = 3,
    parameter int ITER_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         a_init,
    input  logic [15:0]         b_init,
    input  logic [15:0]         c_init,
    input  logic [15:0]         d_init,
    input  logic [ITER_W-1:0]   iter_max,
    grad_descent_ctrl_if.master func_bus,
    output logic [15:0]         a_final,
    output logic [15:0]         b_final,
    output logic [15:0]         c_final,
    output logic [15:0]         d_final,
    output logic [31:0]         z_final,
    output logic [ITER_W-1:0]   iter_count,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_REL, S_UPD, S_DONE} state_t;

    // Perturbation h in raw Q8.8 units, widened for saturating adds.
    localparam logic signed [33:0] H_STEP = 34'(1 << (8 - STEP_SHIFT));

    state_t             state_q, state_d;
    logic [2:0]         sel_q;
    logic               final_q;
    logic               start_func_q;
    logic [31:0]        z_base_q;
    logic [31:0]        z_pert_q [4];
    logic [15:0]        p_q      [4];
    logic [15:0]        op_q     [4];
    logic [15:0]        op_next  [4];
    logic [15:0]        p_new    [4];
    logic signed [31:0] delta    [4];
`ifdef GD_EARLY_STOP_EN
    logic [3:0]         delta_zero;
`endif

    function automatic logic [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'h7FFF;
        else if (v < -34'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    // delta = sat32((z_pert - z_base) << STEP_SHIFT) >>> LR_SHIFT.
    // The difference wraps at 32 bits; only the shifted gradient saturates.
    function automatic logic signed [31:0] calc_delta(input logic [31:0] zp,
                                                      input logic [31:0] zb);
        logic signed [31:0] diff;
        logic signed [63:0] g_wide;
        logic signed [31:0] g;
        diff   = signed'(zp - zb);
        g_wide = 64'(diff) <<< STEP_SHIFT;
        if (g_wide > 64'sh7FFF_FFFF)
            g = 32'sh7FFF_FFFF;
        else if (g_wide < -64'sh8000_0000)
            g = 32'sh8000_0000;
        else
            g = g_wide[31:0];
        return g >>> LR_SHIFT;
    endfunction

    // Operand selection for the next request and the parallel update values.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            op_next[i] = (sel_q == 3'(i + 1)) ? sat16(34'(signed'(p_q[i])) + H_STEP) : p_q[i];
            delta[i]   = calc_delta(z_pert_q[i], z_base_q);
            p_new[i]   = sat16(34'(signed'(p_q[i])) - 34'(delta[i]));
        end
    end

`ifdef GD_EARLY_STOP_EN
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            delta_zero[i] = (delta[i] == 32'sd0);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // REL only moves on once func_done has dropped, so a new request can
    // never be raised against a result still being presented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (func_bus.func_done) state_d = S_REL;
            S_REL: begin
                if (!func_bus.func_done) begin
                    if (final_q)
                        state_d = S_DONE;
                    else if (sel_q == 3'd4)
                        state_d = S_UPD;
                    else
                        state_d = S_REQ;
                end
            end
            S_UPD:  state_d = S_REQ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // final_q marks the next base evaluation as the last one of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            final_q      <= 1'b0;
            start_func_q <= 1'b0;
            z_base_q     <= '0;
            iter_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            a_final      <= '0;
            b_final      <= '0;
            c_final      <= '0;
            d_final      <= '0;
            z_final      <= '0;
            for (int i = 0; i < 4; i++) begin
                p_q[i]      <= '0;
                z_pert_q[i] <= '0;
                op_q[i]     <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        p_q[0]     <= a_init;
                        p_q[1]     <= b_init;
                        p_q[2]     <= c_init;
                        p_q[3]     <= d_init;
                        iter_count <= '0;
                        sel_q      <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        final_q    <= (iter_max == '0);
                    end
                end
                S_REQ: begin
                    for (int i = 0; i < 4; i++) begin
                        op_q[i] <= op_next[i];
                    end
                    start_func_q <= 1'b1;
                end
                S_WAIT: begin
                    if (func_bus.func_done) begin
                        if (sel_q == 3'd0)
                            z_base_q <= func_bus.z_in;
                        else
                            z_pert_q[2'(sel_q - 3'd1)] <= func_bus.z_in;
                        start_func_q <= 1'b0;
                    end
                end
                S_REL: begin
                    if (!func_bus.func_done && !final_q && sel_q != 3'd4)
                        sel_q <= sel_q + 3'd1;
                end
                S_UPD: begin
                    for (int i = 0; i < 4; i++) begin
                        p_q[i] <= p_new[i];
                    end
                    iter_count <= iter_count + ITER_W'(1);
                    sel_q      <= '0;
`ifdef GD_EARLY_STOP_EN
                    final_q    <= (iter_count + ITER_W'(1) == iter_max) || (delta_zero == 4'hF);
`else
                    final_q    <= (iter_count + ITER_W'(1) == iter_max);
`endif
                end
                S_DONE: begin
                    a_final <= p_q[0];
                    b_final <= p_q[1];
                    c_final <= p_q[2];
                    d_final <= p_q[3];
                    z_final <= z_base_q;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign func_bus.start_func = start_func_q;
    assign func_bus.a_out      = op_q[0];
    assign func_bus.b_out      = op_q[1];
    assign func_bus.c_out      = op_q[2];
    assign func_bus.d_out      = op_q[3];

endmodule

// File: tb/tb_grad_descent_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grad_descent_ctrl
// Bench for grad_descent_ctrl with an evaluator stub whose results, latency
// and func_done release delay are programmable. The stub returns result
// slot (request index within the run) mod 5: base, a, b, c, d.
// ---------------------------------------------------------------------------
module tb_grad_descent_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a_init, b_init, c_init, d_init;
    logic [7:0]  iter_max;
    logic [15:0] a_final, b_final, c_final, d_final;
    logic [31:0] z_final;
    logic [7:0]  iter_count;
    logic        busy, done;

    grad_descent_ctrl_if gif();

    grad_descent_ctrl #(.STEP_SHIFT(4), .LR_SHIFT(3), .ITER_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_init     (a_init),
        .b_init     (b_init),
        .c_init     (c_init),
        .d_init     (d_init),
        .iter_max   (iter_max),
        .func_bus   (gif),
        .a_final    (a_final),
        .b_final    (b_final),
        .c_final    (c_final),
        .d_final    (d_final),
        .z_final    (z_final),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] init;
        logic [7:0]  iter_max;
        logic [31:0] z_base, z_a, z_b, z_c, z_d;
        int          latency;
        int          rel_delay;
        logic [63:0] exp_fin;
        logic [31:0] exp_z;
        logic [7:0]  exp_iter;
        int          exp_reqs;
        logic [63:0] exp_ops1;
    } vec_t;

    vec_t vecs [7];

    // Evaluator stub state
    logic [31:0] zt [5];
    int          latency_cfg = 2;
    int          rel_cfg     = 0;
    int          run_base    = 0;
    int          req_count   = 0;
    int          viol_rise   = 0;
    int          viol_stab   = 0;
    logic [63:0] ops_log [$];
    logic [63:0] cur_ops;
    logic [63:0] bus_ops;
    int          phase, cnt, idx;
    logic        prev_sf;

    int tests    = 0;
    int failures = 0;

    assign bus_ops = {gif.a_out, gif.b_out, gif.c_out, gif.d_out};

    // Stub: answers each request after latency_cfg cycles, keeps func_done
    // high for rel_cfg cycles after start_func drops, and logs handshake
    // violations (request raised over a live result, operands moving).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gif.func_done <= 1'b0;
            gif.z_in      <= '0;
            phase         <= 0;
            cnt           <= 0;
            idx           <= 0;
            prev_sf       <= 1'b0;
        end else begin
            prev_sf <= gif.start_func;
            if (gif.start_func && !prev_sf && gif.func_done)
                viol_rise <= viol_rise + 1;
            case (phase)
                0: begin
                    if (gif.start_func) begin
                        cur_ops <= bus_ops;
                        ops_log.push_back(bus_ops);
                        idx       <= (req_count - run_base) % 5;
                        req_count <= req_count + 1;
                        cnt       <= latency_cfg;
                        phase     <= 1;
                    end
                end
                1: begin
                    if (gif.start_func && bus_ops != cur_ops)
                        viol_stab <= viol_stab + 1;
                    if (cnt <= 1) begin
                        gif.func_done <= 1'b1;
                        gif.z_in      <= zt[idx];
                        phase         <= 2;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                2: begin
                    if (gif.start_func && bus_ops != cur_ops)
                        viol_stab <= viol_stab + 1;
                    if (!gif.start_func) begin
                        if (rel_cfg == 0) begin
                            gif.func_done <= 1'b0;
                            phase         <= 0;
                        end else begin
                            cnt   <= rel_cfg;
                            phase <= 3;
                        end
                    end
                end
                3: begin
                    if (cnt <= 1) begin
                        gif.func_done <= 1'b0;
                        phase         <= 0;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                default: phase <= 0;
            endcase
        end
    end

    function automatic logic [63:0] log_at(input int k);
        if (k < ops_log.size())
            return ops_log[k];
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic configure(input vec_t v);
        zt[0]       = v.z_base;
        zt[1]       = v.z_a;
        zt[2]       = v.z_b;
        zt[3]       = v.z_c;
        zt[4]       = v.z_d;
        latency_cfg = v.latency;
        rel_cfg     = v.rel_delay;
        {a_init, b_init, c_init, d_init} = v.init;
        iter_max    = v.iter_max;
    endtask

    // Runs one vector to completion; optionally pulses start mid-run with a
    // different a_init, which must be ignored.
    task automatic applyStimulus(input vec_t v, input bit poke, output int log_base,
                                 output int viol_base);
        bit finished;
        configure(v);
        @(negedge clk);
        run_base  = req_count;
        log_base  = ops_log.size();
        viol_base = viol_rise + viol_stab;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("done_cleared", done, 0);
        if (poke) begin
            repeat (10) @(negedge clk);
            a_init = 16'h1111;
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
        end
        finished = 1'b0;
        for (int c = 0; c < 5000 && !finished; c++) begin
            if (done)
                finished = 1'b1;
            else
                @(negedge clk);
        end
        if (!finished) begin
            tests++;
            failures++;
            $display("[TB] FAIL run_timeout: done=0 after 5000 cycles, expected 1");
        end
    endtask

    task automatic checkRun(input string tag, input vec_t v, input int log_base,
                            input int viol_base);
        checkOutput({tag, "_finals"}, {a_final, b_final, c_final, d_final}, v.exp_fin);
        checkOutput({tag, "_z_final"}, z_final, v.exp_z);
        checkOutput({tag, "_iter_count"}, iter_count, v.exp_iter);
        checkOutput({tag, "_requests"}, req_count - run_base, v.exp_reqs);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_base_ops"}, log_at(log_base), v.init);
        if (v.exp_reqs > 1)
            checkOutput({tag, "_pert_a_ops"}, log_at(log_base + 1), v.exp_ops1);
        checkOutput({tag, "_handshake_viol"}, viol_rise + viol_stab - viol_base, 0);
    endtask

    initial begin
        int   lb, vb;
        bit   seen;
        vec_t v;

        rst_n = 1'b0;
        start = 1'b0;
        {a_init, b_init, c_init, d_init} = '0;
        iter_max = '0;

        //        init                                     itm  base          a             b             c             d            lat rel exp_fin                                     exp_z         it   reqs exp_ops1
        vecs[0] = '{64'h0,                                 8'd1, 32'h300,     32'h2C1,      32'h301,      32'h33F,      32'h300,      2, 0, {16'h007E,16'hFFFE,16'hFF82,16'h0000}, 32'h300,      8'd1, 6, {16'h0010,16'h0000,16'h0000,16'h0000}};
        vecs[1] = '{{16'h7FF8,16'h0,16'h0,16'h0},          8'd1, 32'h100000,  32'h0,        32'h100000,   32'h100000,   32'h100000,   3, 1, {16'h7FFF,16'h0000,16'h0000,16'h0000}, 32'h100000,   8'd1, 6, {16'h7FFF,16'h0000,16'h0000,16'h0000}};
        vecs[2] = '{{16'h0100,16'hFF00,16'h0040,16'h8000}, 8'd2, 32'h1000,    32'h1010,     32'h0FF0,     32'h1000,     32'h101000,   1, 2, {16'h00C0,16'hFF40,16'h0040,16'h8000}, 32'h1000,     8'd2, 11, {16'h0110,16'hFF00,16'h0040,16'h8000}};
        vecs[3] = '{{16'h0005,16'h0005,16'h0005,16'h0005}, 8'd1, 32'h80000000,32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000001, 1, 0, {16'h0007,16'h0007,16'h7FFF,16'h0003}, 32'h80000000, 8'd1, 6, {16'h0015,16'h0005,16'h0005,16'h0005}};
        vecs[4] = '{{16'h1234,16'hABCD,16'h0001,16'hFFFF}, 8'd0, 32'h00ABCDEF,32'h0,        32'h0,        32'h0,        32'h0,        4, 1, {16'h1234,16'hABCD,16'h0001,16'hFFFF}, 32'h00ABCDEF, 8'd0, 1, 64'h0};
`ifdef GD_EARLY_STOP_EN
        vecs[5] = '{{16'h0100,16'h0200,16'h0300,16'h0400}, 8'd10,32'h500,     32'h500,      32'h500,      32'h500,      32'h500,      1, 0, {16'h0100,16'h0200,16'h0300,16'h0400}, 32'h500,      8'd1, 6, {16'h0110,16'h0200,16'h0300,16'h0400}};
`else
        vecs[5] = '{{16'h0100,16'h0200,16'h0300,16'h0400}, 8'd10,32'h500,     32'h500,      32'h500,      32'h500,      32'h500,      1, 0, {16'h0100,16'h0200,16'h0300,16'h0400}, 32'h500,      8'd10, 51, {16'h0110,16'h0200,16'h0300,16'h0400}};
`endif
        vecs[6] = '{64'h0,                                 8'd1, 32'h300,     32'h2C1,      32'h301,      32'h33F,      32'h300,      20, 3, {16'h007E,16'hFFFE,16'hFF82,16'h0000}, 32'h300,     8'd1, 6, {16'h0010,16'h0000,16'h0000,16'h0000}};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_start_func", gif.start_func, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_iter_count", iter_count, 0);
        checkOutput("rst_finals", {a_final, b_final, c_final, d_final}, 0);
        checkOutput("rst_z_final", z_final, 0);
        checkOutput("rst_operands", bus_ops, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 1'b0, lb, vb);
            checkOutput($sformatf("v%0d_done", i), done, 1);
            checkRun($sformatf("v%0d", i), vecs[i], lb, vb);
        end

        // Start pulsed while busy must not restart or reload the run
        applyStimulus(vecs[0], 1'b1, lb, vb);
        checkRun("busy_start", vecs[0], lb, vb);

        // Reset while waiting on a slow evaluator
        v = vecs[2];
        v.latency = 20;
        configure(v);
        @(negedge clk);
        run_base = req_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (gif.start_func)
                seen = 1'b1;
            else
                @(negedge clk);
        end
        checkOutput("midrst_req_seen", seen, 1);
        repeat (3) @(negedge clk);
        checkOutput("midrst_pre_operands", bus_ops, v.init);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_start_func", gif.start_func, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_operands", bus_ops, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(vecs[2], 1'b0, lb, vb);
        checkRun("after_rst", vecs[2], lb, vb);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
